// File: rtl/gate_bist_pkg.sv
// Shared types and constants for the gate-model BIST controller.
// Tap masks select the feedback bits of the LFSR (x^11+x^9+1) and MISR (x^10+x^7+1).
package gate_bist_pkg;

    localparam int DEF_IN_W  = 11;
    localparam int DEF_OUT_W = 10;
    localparam int CNT_W     = 12;

    localparam logic [10:0] LFSR_TAP = 11'h500;
    localparam logic [9:0]  MISR_TAP = 10'h240;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/gate_bist_misr.sv
// Multiple-input signature register: shift with tap feedback, xor in the response word.
// Reset clears to zero; load restores the run seed.
module gate_bist_misr
    import gate_bist_pkg::*;
#(
    parameter int           W    = DEF_OUT_W,
    parameter logic [W-1:0] TAP  = W'(MISR_TAP),
    parameter logic [W-1:0] SEED = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q <= '0;
        else if (load)
            q <= SEED;
        else if (en)
            q <= {q[W-2:0], ^(q & TAP)} ^ d;
    end

endmodule

// File: rtl/gate_bist_ctrl.sv
// BIST controller: LFSR pattern generator, run counter and FSM driving a combinational
// gate model, with the response compacted by gate_bist_misr.
module gate_bist_ctrl
    import gate_bist_pkg::*;
#(
    parameter int              IN_W       = DEF_IN_W,
    parameter int              OUT_W      = DEF_OUT_W,
    parameter int              N_PATTERNS = 2047,
    parameter logic [IN_W-1:0] LFSR_SEED  = IN_W'(1),
    parameter logic [OUT_W-1:0] MISR_SEED = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [OUT_W-1:0] golden_i,
    input  logic [OUT_W-1:0] resp_i,
    output logic [IN_W-1:0]  pattern_o,
    output logic             busy,
    output logic             done,
    output logic             pass_o,
    output logic [OUT_W-1:0] signature_o,
    output logic [CNT_W-1:0] pattern_cnt
);

    localparam logic [1:0] IDLE = 2'(ST_IDLE);
    localparam logic [1:0] RUN  = 2'(ST_RUN);
    localparam logic [1:0] DONE = 2'(ST_DONE);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_PATTERNS - 1);

    logic [1:0]       state;
    logic [IN_W-1:0]  lfsr;
    logic [CNT_W-1:0] cnt;
    logic             go;
    logic             step;

    // start is only honoured outside RUN, and abort overrides it
    assign go   = start && !abort && (state != RUN);
    assign step = (state == RUN) && !abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            lfsr  <= LFSR_SEED;
            cnt   <= '0;
        end else if (abort) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state <= RUN;
                        lfsr  <= LFSR_SEED;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    lfsr <= {lfsr[IN_W-2:0], ^(lfsr & IN_W'(LFSR_TAP))};
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST_CNT)
                        state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    gate_bist_misr #(
        .W    (OUT_W),
        .TAP  (OUT_W'(MISR_TAP)),
        .SEED (MISR_SEED)
    ) u_misr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (go),
        .en    (step),
        .d     (resp_i),
        .q     (signature_o)
    );

    assign busy        = (state == RUN);
    assign done        = (state == DONE);
    assign pattern_o   = busy ? lfsr : '0;
    assign pass_o      = done && (signature_o == golden_i);
    assign pattern_cnt = cnt;

endmodule
